// File: rtl/dutif_flash_trace.sv
// Command monitor and trace block for the DUT SPI flash interface.
// Counts every decoded flash opcode (total plus N_CH programmable per-opcode
// channels) and keeps a timestamped command log FIFO readable over a
// single-cycle-ack Wishbone slave.
module dutif_flash_trace #(
    parameter int N_CH      = 4,
    parameter int LOG_DEPTH = 16,
    parameter int TS_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  mon_cmd,
    input  logic        mon_stb,
    input  logic        dut_rst_n,
    input  logic [15:0] wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);

    localparam int AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int EW = TS_W + 8;

    // Bus registers
    logic              wb_ack_r;
    logic [31:0]       wb_rdata_r;

    // Control / status state
    logic              enable_r;
    logic              overwrite_r;
    logic              ovf_r;
    logic [TS_W-1:0]   ts_r;
    logic [31:0]       total_r;

    // Match channels
    logic [7:0]        op_r  [N_CH];
    logic [23:0]       cnt_r [N_CH];

    // Log FIFO
    logic [EW-1:0]     mem_r [LOG_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;

    // Decoded strobes
    logic              acc_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [3:0]        addr_s;
    logic              csr_wr_s;
    logic              total_wr_s;
    logic              clear_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              do_write_s;
    logic              drop_old_s;
    logic              rd_adv_s;
    logic              ovf_set_s;
    logic [EW-1:0]     head_s;
    logic [N_CH-1:0]   ch_sel_s;
    logic [N_CH-1:0]   ch_wr_s;
    logic [31:0]       ch_rd_s;
    logic [31:0]       rd_val_s;
    logic              unused_s;

    assign wb_ack   = wb_ack_r;
    assign wb_rdata = wb_rdata_r;

    // An access takes effect only on the edge that raises ack, so each
    // request produces exactly one side effect.
    assign acc_s      = wb_cyc & ~wb_ack_r;
    assign wr_acc_s   = acc_s & wb_we;
    assign rd_acc_s   = acc_s & ~wb_we;
    assign addr_s     = wb_addr[3:0];
    assign csr_wr_s   = wr_acc_s & (addr_s == 4'h0);
    assign total_wr_s = wr_acc_s & (addr_s == 4'h1);
    assign clear_s    = csr_wr_s & wb_wdata[2];

    assign empty_s = (level_r == {LW{1'b0}});
    assign full_s  = (level_r == LW'(LOG_DEPTH));
    assign head_s  = mem_r[rd_ptr_r];

    // FIFO arbitration: a pop and a push on the same edge never overflow;
    // a push into a full FIFO without a pop either drops the new entry or
    // evicts the oldest, depending on the overwrite policy.
    assign pop_s      = rd_acc_s & (addr_s == 4'h2) & ~empty_s;
    assign push_s     = enable_r & mon_stb & ~clear_s;
    assign do_write_s = push_s & (~full_s | pop_s | overwrite_r);
    assign drop_old_s = push_s & full_s & ~pop_s & overwrite_r;
    assign rd_adv_s   = pop_s | drop_old_s;
    assign ovf_set_s  = push_s & full_s & ~pop_s;

    assign unused_s = ^{wb_addr[15:4], wb_wdata[31:11], wb_wdata[9:8]};

    // Channel address decode and read-data gather without an oversized index
    always_comb begin
        ch_sel_s = {N_CH{1'b0}};
        ch_rd_s  = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            ch_sel_s[i] = (addr_s == 4'(8 + i));
            ch_rd_s     = ch_rd_s | ({32{ch_sel_s[i]}} & {cnt_r[i], op_r[i]});
        end
        ch_wr_s = ch_sel_s & {N_CH{wr_acc_s}};
    end

    // Register read multiplexer; unmapped addresses read as zero
    always_comb begin
        rd_val_s = 32'h0;
        case (addr_s)
            4'h0: rd_val_s = {7'b0, 9'(level_r), 5'b0, ovf_r, full_s, empty_s,
                              6'b0, overwrite_r, enable_r};
            4'h1: rd_val_s = total_r;
            4'h2: rd_val_s = empty_s ? 32'h0
                                     : {1'b1, 23'(head_s[EW-1:8]), head_s[7:0]};
            4'h3: rd_val_s = 32'(ts_r);
            default: rd_val_s = ch_rd_s;
        endcase
    end

    // Wishbone ack and registered read data, zero outside the ack cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ack_r   <= 1'b0;
            wb_rdata_r <= 32'h0;
        end else begin
            wb_ack_r <= acc_s;
            if (acc_s) begin
                wb_rdata_r <= rd_val_s;
            end else begin
                wb_rdata_r <= 32'h0;
            end
        end
    end

    // CSR bits, sticky overflow and the free-running timestamp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_r    <= 1'b0;
            overwrite_r <= 1'b0;
            ovf_r       <= 1'b0;
            ts_r        <= {TS_W{1'b0}};
        end else begin
            if (csr_wr_s) begin
                enable_r    <= wb_wdata[0];
                overwrite_r <= wb_wdata[1];
            end
            if (clear_s) begin
                ovf_r <= 1'b0;
            end else if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (csr_wr_s && wb_wdata[10]) begin
                ovf_r <= 1'b0;
            end
            if (clear_s) begin
                ts_r <= {TS_W{1'b0}};
            end else if (enable_r) begin
                ts_r <= ts_r + TS_W'(1);
            end
        end
    end

    // Log FIFO storage, pointers and fill level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            for (int i = 0; i < LOG_DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (clear_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (do_write_s) begin
                mem_r[wr_ptr_r] <= {ts_r, mon_cmd};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_write_s, rd_adv_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Total command counter; DUT reset and bus clear both win over a strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_r <= 32'h0;
        end else if (!dut_rst_n || total_wr_s) begin
            total_r <= 32'h0;
        end else if (mon_stb) begin
            total_r <= total_r + 32'd1;
        end
    end

    // Per-channel opcode registers and saturating match counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                op_r[i]  <= 8'h00;
                cnt_r[i] <= 24'h0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_wr_s[i]) begin
                    op_r[i] <= wb_wdata[7:0];
                end
                if (!dut_rst_n || ch_wr_s[i]) begin
                    cnt_r[i] <= 24'h0;
                end else if (mon_stb && (op_r[i] == mon_cmd)
                             && (cnt_r[i] != 24'hFFFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dutif_flash_trace.sv
// Directed self-checking bench for dutif_flash_trace (default parameters).
module tb_dutif_flash_trace;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mon_cmd;
    logic        mon_stb;
    logic        dut_rst_n;
    logic [15:0] wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    int n_tests = 0;
    int n_fail  = 0;

    dutif_flash_trace dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mon_cmd   (mon_cmd),
        .mon_stb   (mon_stb),
        .dut_rst_n (dut_rst_n),
        .wb_addr   (wb_addr),
        .wb_rdata  (wb_rdata),
        .wb_wdata  (wb_wdata),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One bus access, optionally with a coincident monitor strobe.
    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic stb, input logic [7:0] cmd, output logic [31:0] rd);
        @(negedge clk);
        wb_cyc = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wd;
        mon_stb = stb; mon_cmd = cmd;
        @(posedge clk); #1;
        check_eq("ack_rise", {31'b0, wb_ack}, 32'd1);
        rd = wb_rdata;
        @(negedge clk);
        wb_cyc = 1'b0; wb_we = 1'b0; mon_stb = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_fall", {31'b0, wb_ack}, 32'd0);
        check_eq("rdata_idle", wb_rdata, 32'd0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] wd);
        logic [31:0] r;
        bus(1'b1, addr, wd, 1'b0, 8'h00, r);
    endtask

    task automatic rd_expect(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, addr, 32'h0, 1'b0, 8'h00, r);
        check_eq(tag, r, exp);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] cmd, output logic [31:0] r);
        bus(1'b0, 16'h0002, 32'h0, 1'b0, 8'h00, r);
        check_eq(tag, r & 32'hFF0000FF, {24'h800000, cmd});
    endtask

    task automatic strobe(input logic [7:0] cmd);
        @(negedge clk);
        mon_stb = 1'b1; mon_cmd = cmd;
        @(negedge clk);
        mon_stb = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] prev_ts;

        rst_n = 1'b0; dut_rst_n = 1'b1; mon_cmd = 8'h00; mon_stb = 1'b0;
        wb_addr = 16'h0; wb_wdata = 32'h0; wb_we = 1'b0; wb_cyc = 1'b0;
        prev_ts = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {31'b0, wb_ack}, 32'd0);
        check_eq("rst_rdata", wb_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rd_expect("rst_csr", 16'h0000, 32'h00000100);
        rd_expect("rst_total", 16'h0001, 32'h0);
        rd_expect("rst_pop", 16'h0002, 32'h0);
        rd_expect("rst_ts", 16'h0003, 32'h0);

        // Counting with two channels on the same opcode
        wr(16'h0008, 32'h00000003);
        wr(16'h0009, 32'h00000003);
        wr(16'h0000, 32'h00000001);
        for (int i = 0; i < 5; i++) strobe(8'h03);
        for (int i = 0; i < 2; i++) strobe(8'hAB);
        rd_expect("total7", 16'h0001, 32'd7);
        rd_expect("ch0", 16'h0008, 32'h00000503);
        rd_expect("ch1", 16'h0009, 32'h00000503);
        rd_expect("ch2", 16'h000A, 32'h0);
        rd_expect("ch_oob", 16'h000C, 32'h0);
        rd_expect("unmapped", 16'h0004, 32'h0);

        // Drop-new overflow policy
        wr(16'h0000, 32'h00000005);
        for (int i = 0; i < 20; i++) strobe(8'(i));
        rd_expect("csr_full_drop", 16'h0000, 32'h00100601);
        for (int i = 0; i < 16; i++) begin
            pop_expect("pop_drop", 8'(i), r);
            if (i > 0) check_eq("ts_step_drop", {16'h0, r[23:8]}, {16'h0, prev_ts + 16'd2});
            prev_ts = r[23:8];
        end
        rd_expect("pop_empty", 16'h0002, 32'h0);
        rd_expect("csr_after_drain", 16'h0000, 32'h00000501);

        // Discard-oldest overflow policy
        wr(16'h0000, 32'h00000007);
        for (int i = 0; i < 20; i++) strobe(8'(i));
        rd_expect("csr_full_ovw", 16'h0000, 32'h00100603);
        for (int i = 4; i < 20; i++) begin
            pop_expect("pop_ovw", 8'(i), r);
            if (i > 4) check_eq("ts_step_ovw", {16'h0, r[23:8]}, {16'h0, prev_ts + 16'd2});
            prev_ts = r[23:8];
        end
        rd_expect("pop_empty_ovw", 16'h0002, 32'h0);

        // Pop coincident with push on a full FIFO
        wr(16'h0000, 32'h00000007);
        for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
        rd_expect("csr_full_noovf", 16'h0000, 32'h00100203);
        bus(1'b0, 16'h0002, 32'h0, 1'b1, 8'h55, r);
        check_eq("pop_push_head", r & 32'hFF0000FF, 32'h80000020);
        rd_expect("csr_pop_push", 16'h0000, 32'h00100203);
        for (int i = 1; i < 16; i++) pop_expect("pop_pp", 8'(8'h20 + i), r);
        pop_expect("pop_pp_last", 8'h55, r);
        rd_expect("pop_pp_empty", 16'h0002, 32'h0);

        // DUT reset window during strobes
        wr(16'h0000, 32'h00000005);
        wr(16'h0001, 32'h0);
        @(negedge clk);
        dut_rst_n = 1'b0; mon_stb = 1'b1; mon_cmd = 8'h03;
        repeat (3) @(negedge clk);
        dut_rst_n = 1'b1; mon_stb = 1'b0;
        rd_expect("dr_total", 16'h0001, 32'h0);
        rd_expect("dr_ch0", 16'h0008, 32'h00000003);
        rd_expect("dr_ch1", 16'h0009, 32'h00000003);
        rd_expect("dr_csr", 16'h0000, 32'h00030001);
        for (int i = 0; i < 3; i++) pop_expect("dr_pop", 8'h03, r);

        // Counting resumes, and a bus clear beats a coincident strobe
        strobe(8'h03);
        rd_expect("resume_total", 16'h0001, 32'd1);
        rd_expect("resume_ch0", 16'h0008, 32'h00000103);
        bus(1'b1, 16'h0008, 32'h00000003, 1'b1, 8'h03, r);
        rd_expect("clr_ch0_stb", 16'h0008, 32'h00000003);
        rd_expect("ch1_counted", 16'h0009, 32'h00000203);
        bus(1'b1, 16'h0001, 32'h0, 1'b1, 8'h03, r);
        rd_expect("clr_total_stb", 16'h0001, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
